aes_ctr_seq: RTL and testbench
==============================

AES_CTR_SEQ -- requirements
Module: aes_ctr_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; the ports SHALL be named aclk and aresetn.
REQ-002 Port list (name  direction  width  meaning):
- aclk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- cfg_iv  in  128  initial counter block, sampled on cfg_start
- cfg_nblocks  in  16  number of blocks to process, sampled on cfg_start
- cfg_start  in  1  one-cycle start request
- busy  out  1  high while a job is in progress
- done  out  1  one-cycle pulse at job completion
- blk_cnt  out  16  blocks completed in the current or last job
- pt_tvalid / pt_tready / pt_tdata  in / out / in  1 / 1 / 128  plaintext input stream
- ct_tvalid / ct_tready / ct_tdata  out / in / out  1 / 1 / 128  ciphertext output stream
- core_start  out  1  one-cycle pulse to the AES core
- core_block  out  128  counter block presented to the AES core
- core_done  in  1  one-cycle AES completion pulse
- core_result  in  128  keystream block, valid when core_done=1

Function
REQ-003 The FSM SHALL have five states: IDLE, REQ, WAIT, XOR, OUT.
REQ-004 In IDLE with cfg_start=1: ctr<=cfg_iv, remaining<=cfg_nblocks, blk_cnt<=0.
- If cfg_nblocks != 0: go to REQ and set busy=1 on the next cycle.
- If cfg_nblocks == 0: pulse done on the next cycle, stay in IDLE, never assert core_start.
REQ-005 REQ SHALL assert core_start for exactly one cycle with core_block=ctr, then go to WAIT.
REQ-006 core_block SHALL hold ctr stable from REQ until core_done is seen.
REQ-007 In WAIT, on core_done=1: register core_result into the keystream register ks, then go to XOR.
REQ-008 core_done SHALL be ignored in every state other than WAIT.
REQ-009 In XOR: pt_tready=1; on pt_tvalid=1, ct_tdata<=pt_tdata XOR ks, then go to OUT.
REQ-010 pt_tready SHALL be 0 in every state other than XOR.
REQ-011 In OUT: ct_tvalid=1 and ct_tdata SHALL stay stable until ct_tready=1.
REQ-012 On the OUT handshake: blk_cnt+=1 and remaining-=1.
- If remaining was 1: go to IDLE with busy=0 and a one-cycle done pulse.
- Otherwise: increment ctr and go to REQ.
REQ-013 Counter increment SHALL follow the SP800-38A rule:
- ctr[31:0] incremented modulo 2^32 (0xFFFFFFFF wraps to 0x00000000);
- ctr[127:32] unchanged.
REQ-014 cfg_start SHALL be ignored while busy=1.
REQ-015 Minimum per-block latency SHALL be REQ(1) + core latency + XOR(1) + OUT(1) cycles, with zero back-pressure.
REQ-016 blk_cnt SHALL hold its final value after done until the next accepted cfg_start.

Reset
REQ-017 On aresetn=0 the block SHALL asynchronously enter IDLE, in any state.
REQ-018 During reset, busy, done, core_start, pt_tready and ct_tvalid SHALL be 0.
REQ-019 During reset, blk_cnt, core_block, ct_tdata, ks, ctr and remaining SHALL be 0.
REQ-020 After reset release, the first accepted cfg_start SHALL behave exactly as from power-up.

Verification
REQ-021 Reset values: assert aresetn=0 mid-run -> all outputs zero within the same cycle, FSM in IDLE.
REQ-022 Single block: cfg_iv=0x3243f6a8885a308d313198a2e0370734, nblocks=1, core model returns K=0x0F...0F, pt=0x00001111222233334444555566667777 -> core_block=cfg_iv, ct=pt XOR K, done pulse, blk_cnt=1.
REQ-023 Wrap: cfg_iv low word 0xFFFFFFFF, nblocks=2 -> second core_block low word 0x00000000, upper 96 bits unchanged, blk_cnt=2.
REQ-024 Back-pressure: ct_tready=0 for 5 cycles in OUT -> ct_tdata stable, ct_tvalid held, no core_start until the handshake.
REQ-025 Zero length: nblocks=0 -> done one cycle after cfg_start, busy never 1, core_start never 1.
REQ-026 Abort and restart: reset in WAIT, late core_done ignored, new cfg_start with nblocks=3 -> three correct blocks, counters iv, iv+1, iv+2.

Source files
------------

// File: rtl/aes_ctr_seq.sv
// AES-CTR job sequencer: steps a 128-bit counter through an external AES core and XORs the keystream onto plaintext.
// Latency per block: 1 (REQ) + core latency + 1 (XOR) + 1 (OUT) cycles when neither stream stalls.
// Backpressure: pt_tready only in XOR, ct_tdata held in OUT until ct_tready; no new core request before the handshake.
module aes_ctr_seq (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [127:0] cfg_iv,
    input  logic [15:0]  cfg_nblocks,
    input  logic         cfg_start,
    output logic         busy,
    output logic         done,
    output logic [15:0]  blk_cnt,
    input  logic         pt_tvalid,
    output logic         pt_tready,
    input  logic [127:0] pt_tdata,
    output logic         ct_tvalid,
    input  logic         ct_tready,
    output logic [127:0] ct_tdata,
    output logic         core_start,
    output logic [127:0] core_block,
    input  logic         core_done,
    input  logic [127:0] core_result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_XOR  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]   state;
    logic [127:0] ctr;
    logic [127:0] ks;
    logic [127:0] ct_q;
    logic [15:0]  remaining;
    logic [15:0]  blk_cnt_q;
    logic         done_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            ctr       <= '0;
            ks        <= '0;
            ct_q      <= '0;
            remaining <= '0;
            blk_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        ctr       <= cfg_iv;
                        remaining <= cfg_nblocks;
                        blk_cnt_q <= '0;
                        if (cfg_nblocks != 16'd0) begin
                            state <= S_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        ks    <= core_result;
                        state <= S_XOR;
                    end
                end
                S_XOR: begin
                    if (pt_tvalid) begin
                        ct_q  <= pt_tdata ^ ks;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ct_tready) begin
                        blk_cnt_q <= blk_cnt_q + 16'd1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            // Only the low 32-bit word counts; the nonce part never carries.
                            ctr   <= {ctr[127:32], ctr[31:0] + 32'd1};
                            state <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Control outputs decode straight from state so reset clears them immediately.
    assign busy       = (state != S_IDLE);
    assign core_start = (state == S_REQ);
    assign pt_tready  = (state == S_XOR);
    assign ct_tvalid  = (state == S_OUT);
    assign core_block = ctr;
    assign ct_tdata   = ct_q;
    assign done       = done_q;
    assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_ctr_seq.sv
// Directed + randomized bench for aes_ctr_seq with a behavioural AES core stand-in and CTR reference model.
module tb_aes_ctr_seq;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [127:0] cfg_iv;
    logic [15:0]  cfg_nblocks;
    logic         cfg_start;
    logic         busy;
    logic         done;
    logic [15:0]  blk_cnt;
    logic         pt_tvalid;
    logic         pt_tready;
    logic [127:0] pt_tdata;
    logic         ct_tvalid;
    logic         ct_tready;
    logic [127:0] ct_tdata;
    logic         core_start;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;

    int vectors = 0;
    int miscompares = 0;
    int core_lat = 1;
    bit ks_const = 1'b0;
    int starts = 0;
    bit busy_seen = 1'b0;
    logic [127:0] blkq[$];

    always #5 aclk = ~aclk;

    aes_ctr_seq dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_iv(cfg_iv), .cfg_nblocks(cfg_nblocks), .cfg_start(cfg_start),
        .busy(busy), .done(done), .blk_cnt(blk_cnt),
        .pt_tvalid(pt_tvalid), .pt_tready(pt_tready), .pt_tdata(pt_tdata),
        .ct_tvalid(ct_tvalid), .ct_tready(ct_tready), .ct_tdata(ct_tdata),
        .core_start(core_start), .core_block(core_block),
        .core_done(core_done), .core_result(core_result)
    );

    // Stand-in keystream: any fixed bijection of the counter block will do.
    function automatic logic [127:0] ks_of(input logic [127:0] b);
        logic [127:0] k;
        if (ks_const) k = {16{8'h0F}};
        else          k = {b[63:0], b[127:64]} ^ 128'hA5A5_5A5A_C3C3_3C3C_0123_4567_89AB_CDEF;
        return k;
    endfunction

    function automatic logic [127:0] ctr_at(input logic [127:0] iv, input int i);
        return {iv[127:32], iv[31:0] + 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, {123'd0, busy, done, core_start, pt_tready, ct_tvalid}, 128'd0);
        chk({tag, ".blk_cnt"}, 128'(blk_cnt), 128'd0);
        chk({tag, ".core_block"}, core_block, 128'd0);
        chk({tag, ".ct_tdata"}, ct_tdata, 128'd0);
    endtask

    // AES core model: latches core_block on core_start, answers core_lat cycles later.
    initial begin : core_model
        bit pend;
        int cnt;
        logic [127:0] b;
        pend = 1'b0; cnt = 0; b = '0;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge aclk);
            #2;
            core_done = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (core_start) begin
                starts++;
                blkq.push_back(core_block);
            end
            if (pend) begin
                if (cnt == 0) begin
                    core_done   = 1'b1;
                    core_result = ks_of(b);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (core_start) begin
                b    = core_block;
                pend = 1'b1;
                cnt  = core_lat - 1;
            end
        end
    end

    task automatic run_job(input logic [127:0] iv, input int n, input int bp_blk,
                           input int bp_cycles, input bit glitch, input logic [127:0] fixed_pt,
                           input bit use_fixed);
        logic [127:0] pt;
        logic [127:0] exp;
        int s0;
        int s1;
        int t;
        blkq.delete();
        s0 = starts;
        busy_seen = 1'b0;
        @(negedge aclk);
        cfg_iv = iv; cfg_nblocks = 16'(n); cfg_start = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
        if (n == 0) begin
            chk("zero.done", 128'(done), 128'd1);
            chk("zero.busy", 128'(busy), 128'd0);
            @(negedge aclk);
            chk("zero.done_clr", 128'(done), 128'd0);
            chk("zero.blk_cnt", 128'(blk_cnt), 128'd0);
            repeat (3) @(negedge aclk);
            chk("zero.starts", 128'(starts - s0), 128'd0);
            chk("zero.busy_seen", 128'(busy_seen), 128'd0);
            return;
        end
        chk("job.busy", 128'(busy), 128'd1);
        if (glitch) begin
            cfg_iv = ~iv; cfg_nblocks = 16'hFFFF; cfg_start = 1'b1;
            @(negedge aclk);
            cfg_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!pt_tready && t < 200) begin
                @(negedge aclk);
                t++;
            end
            chk("pt_tready_wait", 128'(pt_tready), 128'd1);
            if (!pt_tready) return;
            pt = use_fixed ? fixed_pt : {$urandom, $urandom, $urandom, $urandom};
            pt_tvalid = 1'b1; pt_tdata = pt;
            ct_tready = (i == bp_blk) ? 1'b0 : 1'b1;
            @(negedge aclk);
            pt_tvalid = 1'b0;
            exp = pt ^ ks_of(ctr_at(iv, i));
            chk("ct_tvalid", 128'(ct_tvalid), 128'd1);
            chk("ct_tdata", ct_tdata, exp);
            if (i == bp_blk) begin
                s1 = starts;
                for (int k = 0; k < bp_cycles - 1; k++) begin
                    @(negedge aclk);
                    chk("bp.ct_tvalid", 128'(ct_tvalid), 128'd1);
                    chk("bp.ct_tdata", ct_tdata, exp);
                    chk("bp.no_start", 128'(starts - s1), 128'd0);
                end
                ct_tready = 1'b1;
            end
            @(negedge aclk);
            ct_tready = 1'b0;
            chk("blk_cnt", 128'(blk_cnt), 128'(i + 1));
            if (i == n - 1) begin
                chk("done", 128'(done), 128'd1);
                chk("end.busy", 128'(busy), 128'd0);
            end
        end
        @(negedge aclk);
        chk("done_clr", 128'(done), 128'd0);
        repeat (2) @(negedge aclk);
        chk("blk_cnt_hold", 128'(blk_cnt), 128'(n));
        chk("starts", 128'(starts - s0), 128'(n));
        for (int i = 0; i < n && i < blkq.size(); i++)
            chk("core_block", blkq[i], ctr_at(iv, i));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] iv;
        aresetn = 1'b0;
        cfg_iv = '0; cfg_nblocks = '0; cfg_start = 1'b0;
        pt_tvalid = 1'b0; pt_tdata = '0; ct_tready = 1'b0;
        repeat (3) @(negedge aclk);
        chk_zero("por");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Single known block with constant keystream.
        ks_const = 1'b1; core_lat = 1;
        run_job(128'h3243f6a8885a308d313198a2e0370734, 1, -1, 0, 1'b0,
                128'h00001111222233334444555566667777, 1'b1);
        ks_const = 1'b0;

        // Low-word wrap across two blocks, with a start request arriving while busy.
        core_lat = 2;
        run_job(128'h0123456789ABCDEF_00112233_FFFFFFFF, 2, -1, 0, 1'b1, '0, 1'b0);

        // Back-pressure on the middle block.
        core_lat = 3;
        run_job({$urandom, $urandom, $urandom, $urandom}, 3, 1, 5, 1'b0, '0, 1'b0);

        // Zero-length job.
        run_job({$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 1'b0, '0, 1'b0);

        // Abort in WAIT; the core answers after reset and must be ignored.
        core_lat = 6;
        @(negedge aclk);
        cfg_iv = {$urandom, $urandom, $urandom, $urandom}; cfg_nblocks = 16'd2; cfg_start = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        chk("abort.idle", {123'd0, busy, done, core_start, pt_tready, ct_tvalid}, 128'd0);
        chk("abort.blk_cnt", 128'(blk_cnt), 128'd0);
        core_lat = 2;
        iv = {$urandom, $urandom, $urandom, 32'hFFFF_FFFE};
        run_job(iv, 3, -1, 0, 1'b0, '0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            iv = {$urandom, $urandom, $urandom, $urandom};
            if (j[0]) iv[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            core_lat = $urandom_range(1, 4);
            run_job(iv, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)), '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
